// File: rtl/imem_arbiter_pkg.sv
// Shared definitions for the instruction/data memory arbiter: FSM encodings,
// quad-word/word width macros and the word-lane select helper.
`ifndef IMEM_ARBITER_PKG_SV
`define IMEM_ARBITER_PKG_SV

`ifndef QWORD
`define QWORD 128
`endif
`ifndef WORD
`define WORD 32
`endif

package imem_arbiter_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    GRANT_I = 2'd1,
    GRANT_D = 2'd2,
    RESP    = 2'd3
  } arb_state_e;

  localparam logic SIDE_I = 1'b0;
  localparam logic SIDE_D = 1'b1;

  // Word 0 is the most significant word of the block.
  function automatic logic [`WORD-1:0] word_lane(input logic [`QWORD-1:0] blk,
                                                 input logic [1:0]        sel);
    logic [`WORD-1:0] w;
    case (sel)
      2'd0:    w = blk[127:96];
      2'd1:    w = blk[95:64];
      2'd2:    w = blk[63:32];
      default: w = blk[31:0];
    endcase
    return w;
  endfunction

endpackage

`endif

// File: rtl/imem_arb_watchdog.sv
// Transaction watchdog: counts cycles spent waiting on the memory and raises a
// sticky timeout flag when the wait exceeds TIMEOUT cycles.
module imem_arb_watchdog #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic rst_n,
  input  logic run_i,
  input  logic memReady_i,
  output logic expire_o,
  output logic timeoutErr_o
);

  localparam logic [7:0] LAST_CNT = 8'(TIMEOUT - 1);

  logic [7:0] cnt_q, cnt_d;
  logic       err_q, err_d;

  // A completion arriving on the final cycle wins over the expiry.
  always_comb begin
    expire_o = run_i && !memReady_i && (cnt_q == LAST_CNT);
    cnt_d    = run_i ? cnt_q + 8'd1 : 8'd0;
    err_d    = err_q | expire_o;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= 8'd0;
      err_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      err_q <= err_d;
    end
  end

  assign timeoutErr_o = err_q;

endmodule

// File: rtl/imem_arbiter.sv
// Single-port arbiter sharing one quad-word memory between I-cache refill and
// data accesses. IMEM_ARB_ROUND_ROBIN_EN selects round-robin instead of D-priority.
module imem_arbiter
  import imem_arbiter_pkg::*;
#(
  parameter int TIMEOUT = 255,
  parameter int ADDR_W  = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              icReq,
  input  logic [ADDR_W-1:0] icAddr,
  output logic [127:0]      icQdata,
  output logic              icReady,
  input  logic              dReq,
  input  logic              dWe,
  input  logic [ADDR_W-1:0] dAddr,
  input  logic [31:0]       dWdata,
  output logic [31:0]       dRdata,
  output logic              dReady,
  output logic              memReq,
  output logic              memWe,
  output logic [ADDR_W-1:0] memAddr,
  output logic [31:0]       memWdata,
  input  logic [127:0]      memQdata,
  input  logic              memReady,
  output logic              timeoutErr
);

  arb_state_e        state_q;
  logic              memReq_q;
  logic              memWe_q;
  logic [ADDR_W-1:0] memAddr_q;
  logic [31:0]       memWdata_q;
  logic [1:0]        lane_q;
  logic [127:0]      icQdata_q;
  logic [31:0]       dRdata_q;
  logic              icReady_q;
  logic              dReady_q;

  logic              pick_d;
  logic              wd_run;
  logic              wd_expire;
  logic              done;
  logic              unused_addr_bits;

  assign unused_addr_bits = ^{icAddr[3:0], dAddr[1:0]};

`ifdef IMEM_ARB_ROUND_ROBIN_EN
  logic lastGrant_q;

  // On a tie the side that did not win last time goes first.
  assign pick_d = dReq && (!icReq || (lastGrant_q == SIDE_I));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lastGrant_q <= SIDE_I;
    end else if ((state_q == IDLE) && (icReq || dReq)) begin
      lastGrant_q <= pick_d ? SIDE_D : SIDE_I;
    end
  end
`else
  assign pick_d = dReq;
`endif

  assign wd_run = (state_q == GRANT_I) || (state_q == GRANT_D);
  assign done   = memReady || wd_expire;

  imem_arb_watchdog #(
    .TIMEOUT (TIMEOUT)
  ) u_watchdog (
    .clk          (clk),
    .rst_n        (rst_n),
    .run_i        (wd_run),
    .memReady_i   (memReady),
    .expire_o     (wd_expire),
    .timeoutErr_o (timeoutErr)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      memReq_q   <= 1'b0;
      memWe_q    <= 1'b0;
      memAddr_q  <= '0;
      memWdata_q <= '0;
      lane_q     <= 2'd0;
      icQdata_q  <= '0;
      dRdata_q   <= '0;
      icReady_q  <= 1'b0;
      dReady_q   <= 1'b0;
    end else begin
      icReady_q <= 1'b0;
      dReady_q  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (icReq || dReq) begin
            memReq_q <= 1'b1;
            if (pick_d) begin
              state_q    <= GRANT_D;
              memAddr_q  <= {dAddr[ADDR_W-1:2], 2'b00};
              memWe_q    <= dWe;
              memWdata_q <= dWdata;
              lane_q     <= dAddr[3:2];
            end else begin
              state_q    <= GRANT_I;
              memAddr_q  <= {icAddr[ADDR_W-1:4], 4'b0000};
              memWe_q    <= 1'b0;
              memWdata_q <= '0;
            end
          end
        end
        GRANT_I: begin
          if (done) begin
            state_q   <= RESP;
            memReq_q  <= 1'b0;
            icReady_q <= 1'b1;
            icQdata_q <= memReady ? memQdata : '0;
          end
        end
        GRANT_D: begin
          // Writes and aborted reads both return a zero word.
          if (done) begin
            state_q  <= RESP;
            memReq_q <= 1'b0;
            memWe_q  <= 1'b0;
            dReady_q <= 1'b1;
            dRdata_q <= (memReady && !memWe_q) ? word_lane(memQdata, lane_q) : '0;
          end
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign memReq   = memReq_q;
  assign memWe    = memWe_q;
  assign memAddr  = memAddr_q;
  assign memWdata = memWdata_q;
  assign icQdata  = icQdata_q;
  assign icReady  = icReady_q;
  assign dRdata   = dRdata_q;
  assign dReady   = dReady_q;

endmodule

// File: tb/tb_imem_arbiter.sv
// Self-checking bench for imem_arbiter: vector table plus hand-written sequences
// for arbitration, watchdog, stray completions and reset during a transaction.
module tb_imem_arbiter;

  localparam int TO = 8;
  localparam logic [127:0] Q1 = 128'h11111111_22222222_33333333_44444444;
  localparam logic [127:0] Q2 = 128'hA0A0A0A0_B1B1B1B1_C2C2C2C2_D3D3D3D3;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         icReq;
  logic [31:0]  icAddr;
  logic [127:0] icQdata;
  logic         icReady;
  logic         dReq;
  logic         dWe;
  logic [31:0]  dAddr;
  logic [31:0]  dWdata;
  logic [31:0]  dRdata;
  logic         dReady;
  logic         memReq;
  logic         memWe;
  logic [31:0]  memAddr;
  logic [31:0]  memWdata;
  logic [127:0] memQdata;
  logic         memReady;
  logic         timeoutErr;

  always #5 clk = ~clk;

  imem_arbiter #(.TIMEOUT(TO), .ADDR_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .icReq(icReq), .icAddr(icAddr), .icQdata(icQdata), .icReady(icReady),
    .dReq(dReq), .dWe(dWe), .dAddr(dAddr), .dWdata(dWdata), .dRdata(dRdata), .dReady(dReady),
    .memReq(memReq), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
    .memQdata(memQdata), .memReady(memReady), .timeoutErr(timeoutErr)
  );

  typedef struct { logic is_d; logic [127:0] data; } resp_t;
  typedef struct { logic [31:0] addr; logic we; logic [31:0] wdata; } memx_t;
  typedef struct {
    logic is_d; logic we; logic [31:0] addr; logic [31:0] wdata; int lat;
    logic [127:0] q; logic [31:0] exp_addr; logic [127:0] exp_data;
  } vec_t;

  resp_t        rq[$];
  memx_t        mq[$];
  int           checks = 0;
  int           fails  = 0;
  int           pulses = 0;
  int           mem_lat = 1;
  logic [127:0] mem_data = '0;
  logic         stray = 1'b0;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  // Memory model: responds mem_lat cycles into the request (0 = never).
  initial begin : mem_model
    int    cnt;
    logic  prev;
    memx_t m;
    cnt = 0;
    prev = 1'b0;
    memReady = 1'b0;
    memQdata = '0;
    forever begin
      @(negedge clk);
      memReady = 1'b0;
      if (memReq && !prev) begin
        if (mq.size() == 0) begin
          chk("mem_unexpected_req", mq.size(), 1);
        end else begin
          m = mq.pop_front();
          chk("memAddr", memAddr, m.addr);
          chk("memWe", memWe, m.we);
          if (m.we) chk("memWdata", memWdata, m.wdata);
        end
      end
      prev = memReq;
      if (memReq && mem_lat > 0) begin
        cnt++;
        if (cnt == mem_lat) begin
          memReady = 1'b1;
          memQdata = mem_data;
          cnt = 0;
        end
      end else begin
        cnt = 0;
      end
      if (stray) begin
        memReady = 1'b1;
        memQdata = '1;
        stray = 1'b0;
      end
    end
  end

  // Response scoreboard.
  initial begin : monitor
    resp_t r;
    forever begin
      @(negedge clk);
      if (icReady || dReady) begin
        pulses++;
        chk("ready_exclusive", icReady && dReady, 1'b0);
        if (rq.size() == 0) begin
          chk("unexpected_ready", rq.size(), 1);
        end else begin
          r = rq.pop_front();
          chk("ready_side", dReady, r.is_d);
          chk("resp_data", r.is_d ? {96'b0, dRdata} : icQdata, r.data);
        end
      end
    end
  end

  initial begin : global_guard
    #2_000_000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1);
  end

  task automatic run_txn(input string tag, input vec_t v);
    int    k;
    int    reqc;
    resp_t r;
    memx_t m;
    r.is_d = v.is_d; r.data = v.exp_data; rq.push_back(r);
    m.addr = v.exp_addr; m.we = v.we; m.wdata = v.wdata; mq.push_back(m);
    mem_lat = v.lat;
    mem_data = v.q;
    @(negedge clk);
    if (v.is_d) begin
      dReq = 1'b1; dWe = v.we; dAddr = v.addr; dWdata = v.wdata;
    end else begin
      icReq = 1'b1; icAddr = v.addr;
    end
    k = 0;
    reqc = 0;
    do begin
      @(negedge clk);
      k++;
      if (memReq) reqc++;
    end while (!(v.is_d ? dReady : icReady) && k < 60);
    dReq = 1'b0;
    icReq = 1'b0;
    chk({tag, "_latency"}, k, ((v.lat == 0) ? TO : v.lat) + 1);
    chk({tag, "_memReq_cycles"}, reqc, (v.lat == 0) ? TO : v.lat);
    @(negedge clk);
    chk({tag, "_pulse_width"}, v.is_d ? dReady : icReady, 1'b0);
    chk({tag, "_hold"}, v.is_d ? {96'b0, dRdata} : icQdata, v.exp_data);
  endtask

  initial begin : main
    vec_t  vt[8];
    vec_t  v;
    resp_t r;
    memx_t m;
    int    k, dn, in_n, p0;

    vt[0] = '{1'b0, 1'b0, 32'h0000_1234, 32'h0, 5, Q1, 32'h0000_1230, Q1};
    vt[1] = '{1'b1, 1'b0, 32'h0000_0048, 32'h0, 5, Q1, 32'h0000_0048, 128'h33333333};
    vt[2] = '{1'b1, 1'b1, 32'h0000_0040, 32'hDEAD_BEEF, 1, Q1, 32'h0000_0040, 128'h0};
    vt[3] = '{1'b1, 1'b0, 32'h0000_004F, 32'h0, 1, Q2, 32'h0000_004C, 128'hD3D3D3D3};
    vt[4] = '{1'b1, 1'b0, 32'h0000_0001, 32'h0, 2, Q2, 32'h0000_0000, 128'hA0A0A0A0};
    vt[5] = '{1'b1, 1'b0, 32'h0000_0006, 32'h0, 3, Q2, 32'h0000_0004, 128'hB1B1B1B1};
    vt[6] = '{1'b0, 1'b0, 32'hFFFF_FFFF, 32'h0, 1, Q2, 32'hFFFF_FFF0, Q2};
    vt[7] = '{1'b0, 1'b0, 32'h0000_0100, 32'h0, TO, Q1, 32'h0000_0100, Q1};

    rst_n = 1'b0;
    icReq = 1'b0; icAddr = '0;
    dReq = 1'b0; dWe = 1'b0; dAddr = '0; dWdata = '0;
    repeat (2) @(negedge clk);
    chk("rst_memReq", memReq, 1'b0);
    chk("rst_memWe", memWe, 1'b0);
    chk("rst_memAddr", memAddr, 32'h0);
    chk("rst_memWdata", memWdata, 32'h0);
    chk("rst_icReady", icReady, 1'b0);
    chk("rst_dReady", dReady, 1'b0);
    chk("rst_icQdata", icQdata, 128'h0);
    chk("rst_dRdata", dRdata, 32'h0);
    chk("rst_timeoutErr", timeoutErr, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    chk("idle_memReq", memReq, 1'b0);

    for (int i = 0; i < 8; i++) begin
      run_txn($sformatf("vec%0d", i), vt[i]);
    end
    chk("no_timeout_after_table", timeoutErr, 1'b0);

    // Memory never answers.
    v = '{1'b1, 1'b0, 32'h0000_0048, 32'h0, 0, Q1, 32'h0000_0048, 128'h0};
    run_txn("watchdog", v);
    chk("timeoutErr_set", timeoutErr, 1'b1);
    v = '{1'b0, 1'b0, 32'h0000_1234, 32'h0, 2, Q1, 32'h0000_1230, Q1};
    run_txn("after_timeout", v);
    chk("timeoutErr_sticky", timeoutErr, 1'b1);

    // Completion strobe while nothing is outstanding.
    p0 = pulses;
    @(negedge clk);
    stray = 1'b1;
    repeat (4) @(negedge clk);
    chk("stray_no_pulse", pulses, p0);
    chk("stray_no_memReq", memReq, 1'b0);

    // Requester withdraws mid-transaction.
    r.is_d = 1'b0; r.data = Q2; rq.push_back(r);
    m.addr = 32'h80; m.we = 1'b0; m.wdata = 32'h0; mq.push_back(m);
    mem_lat = 4; mem_data = Q2;
    @(negedge clk);
    icReq = 1'b1; icAddr = 32'h80;
    repeat (2) @(negedge clk);
    icReq = 1'b0;
    k = 2;
    while (!icReady && k < 60) begin
      @(negedge clk);
      k++;
    end
    chk("middrop_latency", k, 5);
    @(negedge clk);

    // Both sides hold their requests across completions.
    mem_lat = 1; mem_data = Q1;
`ifdef IMEM_ARB_ROUND_ROBIN_EN
    rq.push_back('{1'b1, 128'h11111111}); mq.push_back('{32'h40, 1'b0, 32'h0});
    rq.push_back('{1'b0, Q1});            mq.push_back('{32'h200, 1'b0, 32'h0});
    rq.push_back('{1'b1, 128'h22222222}); mq.push_back('{32'h44, 1'b0, 32'h0});
    rq.push_back('{1'b0, Q1});            mq.push_back('{32'h300, 1'b0, 32'h0});
`else
    rq.push_back('{1'b1, 128'h11111111}); mq.push_back('{32'h40, 1'b0, 32'h0});
    rq.push_back('{1'b1, 128'h22222222}); mq.push_back('{32'h44, 1'b0, 32'h0});
    rq.push_back('{1'b0, Q1});            mq.push_back('{32'h200, 1'b0, 32'h0});
    rq.push_back('{1'b0, Q1});            mq.push_back('{32'h300, 1'b0, 32'h0});
`endif
    @(negedge clk);
    dReq = 1'b1; dWe = 1'b0; dAddr = 32'h40;
    icReq = 1'b1; icAddr = 32'h200;
    dn = 0; in_n = 0; k = 0;
    while ((dn < 2 || in_n < 2) && k < 200) begin
      @(negedge clk);
      k++;
      if (dReady) begin
        dn++;
        if (dn == 2) dReq = 1'b0; else dAddr = 32'h44;
      end
      if (icReady) begin
        in_n++;
        if (in_n == 2) icReq = 1'b0; else icAddr = 32'h300;
      end
    end
    dReq = 1'b0; icReq = 1'b0;
    chk("arb_completions", dn + in_n, 4);
    chk("arb_scoreboard_empty", rq.size(), 0);
    @(negedge clk);

    // Reset while an I-side refill is outstanding.
    mq.push_back('{32'h500, 1'b0, 32'h0});
    mem_lat = 0;
    @(negedge clk);
    icReq = 1'b1; icAddr = 32'h500;
    repeat (3) @(negedge clk);
    chk("pre_reset_memReq", memReq, 1'b1);
    p0 = pulses;
    #2 rst_n = 1'b0;
    #1 chk("async_memReq_drop", memReq, 1'b0);
    icReq = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    chk("reset_no_ready", pulses, p0);
    chk("reset_clears_timeoutErr", timeoutErr, 1'b0);
    v = '{1'b0, 1'b0, 32'h0000_0600, 32'h0, 1, Q2, 32'h0000_0600, Q2};
    run_txn("post_reset", v);

    chk("mem_queue_empty", mq.size(), 0);
    $display("%0d/%0d checks passed", checks - fails, checks);
    $finish;
  end

endmodule
